// File: rtl/execute_unit_mc.sv
// Handshaked execute stage: register file, ALU decode, operand-2 mux, registered
// result slot with write-back bypass, and iterative MUL/DIVU/REMU.
module execute_unit_mc #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   parameter int RA_W  = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [1:0]      alu_op,
   input  logic [2:0]      funct3,
   input  logic            funct7_5,
   input  logic            funct7_0,
   input  logic            alu_src,
   input  logic [RA_W-1:0] rs1,
   input  logic [RA_W-1:0] rs2,
   input  logic [RA_W-1:0] rd,
   input  logic [XLEN-1:0] imm,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_result,
   output logic [RA_W-1:0] out_rd,
   output logic            out_zero,
   output logic            out_illegal
);

   localparam int SH_W  = $clog2(XLEN);
   localparam int CNT_W = $clog2(XLEN + 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2
   } state_t;

   state_t            state_r, state_nxt_s;
   logic [XLEN-1:0]   regs_r [NREGS];
   logic [CNT_W-1:0]  cnt_r;
   logic [XLEN-1:0]   mop_a_r, mop_b_r, acc_r;
   logic [RA_W-1:0]   mrd_r;
   logic              is_rem_r;

   logic              accept_s, drain_s, done_s;
   logic [XLEN-1:0]   op1_s, rs2_data_s, op2_s, alu_res_s, done_res_s;
   logic              m_sel_s, is_mul_s, is_div_s, m_illegal_s;
   logic [SH_W-1:0]   shamt_s;
   logic [XLEN-1:0]   mul_acc_nxt_s, div_sub_s;
   logic [XLEN:0]     div_sh_s;
   logic              div_ge_s;

   assign in_ready = (state_r == ST_IDLE) && (!out_valid || out_ready) && !flush;
   assign accept_s = in_valid && in_ready;
   assign drain_s  = out_valid && out_ready;
   assign done_s   = (state_r != ST_IDLE) && (cnt_r == {CNT_W{1'b0}});

   // Operand fetch: x0 reads zero, a draining result bypasses the register file
   always_comb begin
      op1_s      = {XLEN{1'b0}};
      rs2_data_s = {XLEN{1'b0}};
      if (rs1 == {RA_W{1'b0}})          op1_s = {XLEN{1'b0}};
      else if (drain_s && out_rd == rs1) op1_s = out_result;
      else                               op1_s = regs_r[rs1];
      if (rs2 == {RA_W{1'b0}})          rs2_data_s = {XLEN{1'b0}};
      else if (drain_s && out_rd == rs2) rs2_data_s = out_result;
      else                               rs2_data_s = regs_r[rs2];
   end

   assign op2_s       = alu_src ? imm : rs2_data_s;
   assign shamt_s     = op2_s[SH_W-1:0];
   assign m_sel_s     = (alu_op == 2'b10) && funct7_0 && !alu_src;
   assign is_mul_s    = m_sel_s && (funct3 == 3'b000);
   assign is_div_s    = m_sel_s && ((funct3 == 3'b101) || (funct3 == 3'b111));
   assign m_illegal_s = m_sel_s && !is_mul_s && !is_div_s;

   // Single-cycle ALU; unsupported M encodings produce zero
   always_comb begin
      alu_res_s = {XLEN{1'b0}};
      case (alu_op)
         2'b00: alu_res_s = op1_s + op2_s;
         2'b01: alu_res_s = op1_s - op2_s;
         2'b10: begin
            if (m_sel_s) begin
               alu_res_s = {XLEN{1'b0}};
            end else begin
               case (funct3)
                  3'b000: begin
                     if (funct7_5 && !alu_src) alu_res_s = op1_s - op2_s;
                     else                      alu_res_s = op1_s + op2_s;
                  end
                  3'b001: alu_res_s = op1_s << shamt_s;
                  3'b010: alu_res_s = {{(XLEN-1){1'b0}}, ($signed(op1_s) < $signed(op2_s))};
                  3'b011: alu_res_s = {{(XLEN-1){1'b0}}, (op1_s < op2_s)};
                  3'b100: alu_res_s = op1_s ^ op2_s;
                  3'b101: begin
                     if (funct7_5) alu_res_s = $unsigned($signed(op1_s) >>> shamt_s);
                     else          alu_res_s = op1_s >> shamt_s;
                  end
                  3'b110: alu_res_s = op1_s | op2_s;
                  3'b111: alu_res_s = op1_s & op2_s;
                  default: alu_res_s = {XLEN{1'b0}};
               endcase
            end
         end
         default: alu_res_s = {XLEN{1'b0}};
      endcase
   end

   // Iteration step: shift-add multiply, restoring divide (divisor 0 yields all ones / dividend)
   assign mul_acc_nxt_s = acc_r + (mop_b_r[0] ? mop_a_r : {XLEN{1'b0}});
   assign div_sh_s      = {acc_r, mop_a_r[XLEN-1]};
   assign div_ge_s      = div_sh_s >= {1'b0, mop_b_r};
   assign div_sub_s     = XLEN'(div_sh_s - {1'b0, mop_b_r});
   assign done_res_s    = ((state_r == ST_DIV) && !is_rem_r) ? mop_a_r : acc_r;

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_r <= ST_IDLE;
      else        state_r <= state_nxt_s;
   end

   // FSM next-state
   always_comb begin
      state_nxt_s = state_r;
      if (flush) begin
         state_nxt_s = ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (accept_s && is_mul_s)      state_nxt_s = ST_MUL;
               else if (accept_s && is_div_s) state_nxt_s = ST_DIV;
               else                           state_nxt_s = ST_IDLE;
            end
            ST_MUL, ST_DIV: begin
               if (done_s) state_nxt_s = ST_IDLE;
               else        state_nxt_s = state_r;
            end
            default: state_nxt_s = ST_IDLE;
         endcase
      end
   end

   // Multi-cycle operand latch and iteration datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r    <= {CNT_W{1'b0}};
         mop_a_r  <= {XLEN{1'b0}};
         mop_b_r  <= {XLEN{1'b0}};
         acc_r    <= {XLEN{1'b0}};
         mrd_r    <= {RA_W{1'b0}};
         is_rem_r <= 1'b0;
      end else if (flush) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (accept_s && (is_mul_s || is_div_s)) begin
         cnt_r    <= CNT_W'(XLEN);
         mop_a_r  <= op1_s;
         mop_b_r  <= op2_s;
         acc_r    <= {XLEN{1'b0}};
         mrd_r    <= rd;
         is_rem_r <= (funct3 == 3'b111);
      end else if (state_r == ST_MUL && !done_s) begin
         acc_r   <= mul_acc_nxt_s;
         mop_a_r <= mop_a_r << 1;
         mop_b_r <= mop_b_r >> 1;
         cnt_r   <= cnt_r - CNT_W'(1);
      end else if (state_r == ST_DIV && !done_s) begin
         acc_r   <= div_ge_s ? div_sub_s : div_sh_s[XLEN-1:0];
         mop_a_r <= {mop_a_r[XLEN-2:0], div_ge_s};
         cnt_r   <= cnt_r - CNT_W'(1);
      end
   end

   // Output slot: flush wins, then fill (single-cycle or iteration done), then drain
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid   <= 1'b0;
         out_result  <= {XLEN{1'b0}};
         out_rd      <= {RA_W{1'b0}};
         out_zero    <= 1'b0;
         out_illegal <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (accept_s && !is_mul_s && !is_div_s) begin
         out_valid   <= 1'b1;
         out_result  <= alu_res_s;
         out_rd      <= rd;
         out_zero    <= (alu_res_s == {XLEN{1'b0}});
         out_illegal <= m_illegal_s;
      end else if (done_s) begin
         out_valid   <= 1'b1;
         out_result  <= done_res_s;
         out_rd      <= mrd_r;
         out_zero    <= (done_res_s == {XLEN{1'b0}});
         out_illegal <= 1'b0;
      end else if (drain_s) begin
         out_valid <= 1'b0;
      end
   end

   // Register file write-back on drain
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) regs_r[i] <= {XLEN{1'b0}};
      end else if (drain_s && !flush && out_rd != {RA_W{1'b0}}) begin
         regs_r[out_rd] <= out_result;
      end
   end

endmodule

// File: tb/tb_execute_unit_mc.sv
// Scoreboard bench for execute_unit_mc: reference model computes each result at issue.
module tb_execute_unit_mc;

   logic        clk = 1'b0;
   logic        rst_n, flush, in_valid, in_ready;
   logic [1:0]  alu_op;
   logic [2:0]  funct3;
   logic        funct7_5, funct7_0, alu_src;
   logic [4:0]  rs1, rs2, rd;
   logic [31:0] imm;
   logic        out_valid, out_ready, out_zero, out_illegal;
   logic [31:0] out_result;
   logic [4:0]  out_rd;

   typedef struct packed {
      logic [31:0] res;
      logic [4:0]  rd;
      logic        ill;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] mregs [32];
   int          n_checks = 0;
   int          n_fail   = 0;

   execute_unit_mc #(.XLEN(32), .NREGS(32), .RA_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .alu_op(alu_op), .funct3(funct3), .funct7_5(funct7_5), .funct7_0(funct7_0),
      .alu_src(alu_src), .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_rd(out_rd), .out_zero(out_zero), .out_illegal(out_illegal)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference model: returns {illegal, result}
   function automatic logic [32:0] ref_exec(input logic [1:0] op, input logic [2:0] f3,
                                            input logic f75, input logic f70, input logic src,
                                            input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r;
      logic        ill;
      r   = 32'd0;
      ill = 1'b0;
      case (op)
         2'b00: r = a + b;
         2'b01: r = a - b;
         2'b10: begin
            if (f70 && !src) begin
               case (f3)
                  3'b000: r = a * b;
                  3'b101: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
                  3'b111: r = (b == 32'd0) ? a : a % b;
                  default: begin r = 32'd0; ill = 1'b1; end
               endcase
            end else begin
               case (f3)
                  3'b000: r = (f75 && !src) ? a - b : a + b;
                  3'b001: r = a << b[4:0];
                  3'b010: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                  3'b011: r = (a < b) ? 32'd1 : 32'd0;
                  3'b100: r = a ^ b;
                  3'b101: begin
                     if (f75) r = $signed(a) >>> b[4:0];
                     else     r = a >> b[4:0];
                  end
                  3'b110: r = a | b;
                  default: r = a & b;
               endcase
            end
         end
         default: r = 32'd0;
      endcase
      return {ill, r};
   endfunction

   // Scoreboard pop/compare whenever the DUT hands over a result
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_valid", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("result", out_result, e.res);
            check("rd", {27'd0, out_rd}, {27'd0, e.rd});
            check("illegal", {31'd0, out_illegal}, {31'd0, e.ill});
            check("zero", {31'd0, out_zero}, {31'd0, (e.res == 32'd0)});
         end
      end
   end

   task automatic issue(input logic [1:0] op, input logic [2:0] f3, input logic f75,
                        input logic f70, input logic src, input logic [4:0] r1,
                        input logic [4:0] r2, input logic [4:0] d, input logic [31:0] im,
                        input bit track);
      logic [31:0] a, b;
      logic [32:0] rr;
      exp_t        e;
      int          n;
      @(negedge clk);
      alu_op = op; funct3 = f3; funct7_5 = f75; funct7_0 = f70; alu_src = src;
      rs1 = r1; rs2 = r2; rd = d; imm = im; in_valid = 1'b1;
      n = 0;
      #1;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (n >= 100) check("accept_timeout", 32'd0, 32'd1);
      a  = (r1 == 5'd0) ? 32'd0 : mregs[r1];
      b  = src ? im : ((r2 == 5'd0) ? 32'd0 : mregs[r2]);
      rr = ref_exec(op, f3, f75, f70, src, a, b);
      @(posedge clk);
      if (track) begin
         e.res = rr[31:0]; e.rd = d; e.ill = rr[32];
         sb.push_back(e);
         if (d != 5'd0) mregs[d] = rr[31:0];
      end
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((sb.size() != 0 || out_valid) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) check("drain_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      bit early, rdy_seen, unstable;
      for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      alu_op = 2'b00; funct3 = 3'b000; funct7_5 = 1'b0; funct7_0 = 1'b0; alu_src = 1'b0;
      rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0; imm = 32'd0;
      #8;
      check("rst_valid", {31'd0, out_valid}, 32'd0);
      check("rst_result", out_result, 32'd0);
      check("rst_rd", {27'd0, out_rd}, 32'd0);
      check("rst_zero", {31'd0, out_zero}, 32'd0);
      check("rst_illegal", {31'd0, out_illegal}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1 check("rst_in_ready", {31'd0, in_ready}, 32'd1);

      // ADDI x1 = 5, then back-to-back ADD x2 = x1 + x1 via bypass
      issue(2'b10, 3'b000, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd1, 32'd5, 1'b1);
      #3 check("addi_next_cycle", {31'd0, out_valid}, 32'd1);
      issue(2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 5'd1, 5'd1, 5'd2, 32'd0, 1'b1);
      wait_idle();

      // Shifts, compares, logic ops, SUB to x0
      issue(2'b10, 3'b000, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd3, 32'h8000_0000, 1'b1);
      issue(2'b10, 3'b101, 1'b1, 1'b0, 1'b1, 5'd3, 5'd0, 5'd4, 32'd4, 1'b1);
      issue(2'b10, 3'b010, 1'b0, 1'b0, 1'b1, 5'd3, 5'd0, 5'd5, 32'd1, 1'b1);
      issue(2'b10, 3'b011, 1'b0, 1'b0, 1'b1, 5'd3, 5'd0, 5'd6, 32'd1, 1'b1);
      issue(2'b10, 3'b101, 1'b0, 1'b0, 1'b1, 5'd3, 5'd0, 5'd7, 32'd4, 1'b1);
      issue(2'b10, 3'b001, 1'b0, 1'b0, 1'b0, 5'd2, 5'd1, 5'd8, 32'd0, 1'b1);
      issue(2'b10, 3'b100, 1'b0, 1'b0, 1'b0, 5'd4, 5'd8, 5'd9, 32'd0, 1'b1);
      issue(2'b10, 3'b110, 1'b0, 1'b0, 1'b1, 5'd1, 5'd0, 5'd10, 32'h0F0, 1'b1);
      issue(2'b10, 3'b111, 1'b0, 1'b0, 1'b1, 5'd9, 5'd0, 5'd11, 32'h00FF_FF00, 1'b1);
      issue(2'b10, 3'b000, 1'b1, 1'b0, 1'b0, 5'd1, 5'd2, 5'd12, 32'd0, 1'b1);
      issue(2'b01, 3'b000, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd0, 32'd0, 1'b1);
      issue(2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd13, 32'd0, 1'b1);
      wait_idle();

      // MUL 0xFFFFFFFF * 3 with latency and busy checks
      issue(2'b00, 3'b000, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd8, 32'hFFFF_FFFF, 1'b1);
      issue(2'b00, 3'b000, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd9, 32'd3, 1'b1);
      wait_idle();
      issue(2'b10, 3'b000, 1'b0, 1'b1, 1'b0, 5'd8, 5'd9, 5'd10, 32'd0, 1'b1);
      early = 1'b0; rdy_seen = 1'b0;
      for (int k = 1; k <= 33; k++) begin
         @(posedge clk);
         #1;
         if (k <= 32) begin
            if (out_valid) early = 1'b1;
            if (in_ready) rdy_seen = 1'b1;
         end
      end
      check("mul_early_valid", {31'd0, early}, 32'd0);
      check("mul_busy_ready", {31'd0, rdy_seen}, 32'd0);
      check("mul_latency", {31'd0, out_valid}, 32'd1);
      wait_idle();

      // DIVU / REMU, including divide by zero
      issue(2'b00, 3'b000, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd11, 32'd100, 1'b1);
      issue(2'b00, 3'b000, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd12, 32'd7, 1'b1);
      issue(2'b00, 3'b000, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd17, 32'd9, 1'b1);
      issue(2'b10, 3'b101, 1'b0, 1'b1, 1'b0, 5'd11, 5'd12, 5'd13, 32'd0, 1'b1);
      issue(2'b10, 3'b111, 1'b0, 1'b1, 1'b0, 5'd11, 5'd12, 5'd14, 32'd0, 1'b1);
      issue(2'b10, 3'b101, 1'b0, 1'b1, 1'b0, 5'd17, 5'd0, 5'd18, 32'd0, 1'b1);
      issue(2'b10, 3'b111, 1'b0, 1'b1, 1'b0, 5'd17, 5'd0, 5'd19, 32'd0, 1'b1);
      wait_idle();

      // Backpressure: held slot stays stable and does not write back
      @(negedge clk);
      out_ready = 1'b0;
      issue(2'b10, 3'b000, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd20, 32'h55, 1'b1);
      unstable = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (!out_valid || out_result !== 32'h55 || out_rd !== 5'd20 || in_ready
             || dut.regs_r[20] !== 32'd0) unstable = 1'b1;
      end
      check("hold_stable", {31'd0, unstable}, 32'd0);
      out_ready = 1'b1;
      wait_idle();
      issue(2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 5'd20, 5'd0, 5'd21, 32'd0, 1'b1);
      wait_idle();

      // Illegal M encoding
      issue(2'b10, 3'b001, 1'b0, 1'b1, 1'b0, 5'd1, 5'd2, 5'd23, 32'd0, 1'b1);
      wait_idle();

      // Flush mid-DIVU: x13 keeps its old value
      issue(2'b10, 3'b101, 1'b0, 1'b1, 1'b0, 5'd17, 5'd9, 5'd13, 32'd0, 1'b0);
      repeat (10) @(negedge clk);
      flush = 1'b1;
      #1 check("flush_in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      flush = 1'b0;
      check("flush_valid", {31'd0, out_valid}, 32'd0);
      repeat (40) @(negedge clk);
      check("flush_no_result", {31'd0, out_valid}, 32'd0);
      issue(2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 5'd13, 5'd0, 5'd22, 32'd0, 1'b1);
      wait_idle();

      // Async reset mid-MUL
      issue(2'b10, 3'b000, 1'b0, 1'b1, 1'b0, 5'd8, 5'd9, 5'd24, 32'd0, 1'b0);
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_valid", {31'd0, out_valid}, 32'd0);
      check("arst_result", out_result, 32'd0);
      check("arst_rd", {27'd0, out_rd}, 32'd0);
      check("arst_illegal", {31'd0, out_illegal}, 32'd0);
      check("arst_zero", {31'd0, out_zero}, 32'd0);
      for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
      @(negedge clk);
      rst_n = 1'b1;
      issue(2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 5'd22, 5'd0, 5'd25, 32'd0, 1'b1);
      wait_idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
